// File: rtl/subleq_datapath.sv
// SUBLEQ datapath and 13-step state sequencer: operand/PC registers, memory port, flags.
// Optional retired-instruction counter enabled by defining SUBLEQ_INSTR_COUNT_EN.
module subleq_datapath #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  HALT_ADDR = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [3:0]        state,
  output logic              zero,
  output logic              negative,
  input  logic              a_ld,
  input  logic              b_ld,
  input  logic              c_ld,
  input  logic              mem_a_ld,
  input  logic              mem_b_ld,
  input  logic              result_ld,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              pc_ld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count
);

  typedef enum logic [3:0] {
    ST_0    = 4'd0,
    ST_1    = 4'd1,
    ST_2    = 4'd2,
    ST_3    = 4'd3,
    ST_4    = 4'd4,
    ST_5    = 4'd5,
    ST_6    = 4'd6,
    ST_7    = 4'd7,
    ST_8    = 4'd8,
    ST_9    = 4'd9,
    ST_10   = 4'd10,
    ST_11   = 4'd11,
    ST_12   = 4'd12,
    ST_HALT = 4'd13,
    ST_IDLE = 4'd15
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, a_q, b_q, c_q, pc_next;
  logic [DATA_W-1:0]   mem_a_q, mem_b_q, result_q, result_d;
  logic                zero_q, negative_q;
  logic                active;

  assign active   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign pc_next  = pc_ld ? c_q : pc_q + ADDR_W'(3);
  assign result_d = mem_b_q - mem_a_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (start) state_d = ST_0;
      ST_12:            state_d = (pc_next == HALT_ADDR) ? ST_HALT : ST_0;
      ST_0, ST_1, ST_2, ST_3, ST_4, ST_5,
      ST_6, ST_7, ST_8, ST_9, ST_10, ST_11:
                        state_d = state_t'(state_q + 4'd1);
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = pc_q;
    case (state_q)
      ST_0, ST_1:        mem_addr = pc_q;
      ST_2, ST_3:        mem_addr = pc_q + ADDR_W'(1);
      ST_4, ST_5:        mem_addr = pc_q + ADDR_W'(2);
      ST_6, ST_7:        mem_addr = a_q;
      ST_8, ST_9, ST_11: mem_addr = b_q;
      default:           mem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      mem_a_q    <= '0;
      mem_b_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_HALT) begin
        // HALT freezes everything; only a restart touches the PC
        if (start) pc_q <= '0;
      end else begin
        if (a_ld)     a_q     <= mem_rdata[ADDR_W-1:0];
        if (b_ld)     b_q     <= mem_rdata[ADDR_W-1:0];
        if (c_ld)     c_q     <= mem_rdata[ADDR_W-1:0];
        if (mem_a_ld) mem_a_q <= mem_rdata;
        if (mem_b_ld) mem_b_q <= mem_rdata;
        if (result_ld) begin
          result_q   <= result_d;
          zero_q     <= (result_d == '0);
          negative_q <= result_d[DATA_W-1];
        end
        if (state_q == ST_12) pc_q <= pc_next;
      end
    end
  end

`ifdef SUBLEQ_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if ((state_q == ST_HALT) && start) begin
      count_q <= '0;
    end else if (state_q == ST_12) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

  assign state     = state_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign mem_re    = mem_read & active;
  assign mem_we    = mem_write & active;
  assign mem_wdata = result_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);

endmodule
